// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch front end: keeps at most one imem request in
// flight, drops the response of a request overtaken by a redirect, and buffers one instruction.
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] INSTR_NOP = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        take_branch,
   input  logic [31:0] branch_target_NextPC,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr
);

   // Handshakes: a transfer happens on a rising edge where valid && ready. A producer
   // that has raised valid keeps its payload stable until that transfer happens.
   // imem responses carry no ready; they are taken whenever a request is outstanding.

   logic [31:0] pc_q;
   logic [31:0] req_pc;
   logic        outstanding;
   logic        drop;
   logic        buf_valid;
   logic [31:0] buf_pc;
   logic [31:0] buf_instr;

   logic req_fire;
   logic rsp_fire;
   logic buf_take;

   // A new request needs a free buffer slot by the time its response can return.
   assign imem_req_valid = !outstanding && (!buf_valid || if_ready) && !take_branch && !rst;
   assign imem_addr      = pc_q;

   assign req_fire = imem_req_valid && imem_req_ready;
   assign rsp_fire = imem_rsp_valid && outstanding;
   assign buf_take = buf_valid && if_ready;

   assign if_valid = buf_valid;
   assign if_pc    = buf_pc;
   assign if_instr = buf_valid ? buf_instr : INSTR_NOP;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q        <= RESET_PC;
         req_pc      <= RESET_PC;
         outstanding <= 1'b0;
         drop        <= 1'b0;
         buf_valid   <= 1'b0;
         buf_pc      <= 32'h0;
         buf_instr   <= INSTR_NOP;
      end else if (take_branch) begin
         pc_q      <= branch_target_NextPC;
         buf_valid <= 1'b0;
         // A response landing in the redirect cycle is the only stale one, so it is
         // swallowed here and nothing is left to drop; otherwise mark the pending one.
         if (rsp_fire) begin
            outstanding <= 1'b0;
            drop        <= 1'b0;
         end else if (outstanding) begin
            drop <= 1'b1;
         end
      end else begin
         if (req_fire) begin
            outstanding <= 1'b1;
            req_pc      <= pc_q;
            pc_q        <= pc_q + 32'd4;
         end

         if (rsp_fire) begin
            outstanding <= 1'b0;
            drop        <= 1'b0;
         end

         if (rsp_fire && !drop) begin
            buf_valid <= 1'b1;
            buf_pc    <= req_pc;
            buf_instr <= imem_rsp_data;
         end else if (buf_take) begin
            buf_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: the script plays instruction memory and decode,
// pushing every instruction that must reach decode onto exp_q; a monitor pops on each transfer.
module tb_pc_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        take_branch;
   logic [31:0] branch_target_NextPC;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_instr;

   logic [63:0] exp_q[$];
   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   pc_fetch_unit dut (
      .clk                  (clk),
      .rst                  (rst),
      .take_branch          (take_branch),
      .branch_target_NextPC (branch_target_NextPC),
      .imem_req_valid       (imem_req_valid),
      .imem_req_ready       (imem_req_ready),
      .imem_addr            (imem_addr),
      .imem_rsp_valid       (imem_rsp_valid),
      .imem_rsp_data        (imem_rsp_data),
      .if_valid             (if_valid),
      .if_ready             (if_ready),
      .if_pc                (if_pc),
      .if_instr             (if_instr)
   );

   function automatic logic [31:0] ins(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive a memory response for address a; deliver=1 means decode must see it.
   task automatic rsp(input logic [31:0] a, input bit deliver);
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = ins(a);
      if (deliver) exp_q.push_back({a, ins(a)});
   endtask

   task automatic rsp_idle();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
   endtask

   // Decode side: every accepted instruction outside a redirect cycle must be the next expected one.
   always @(negedge clk) begin : monitor
      logic [63:0] e;
      if (!rst && if_valid && if_ready && !take_branch) begin
         chk("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_pc", if_pc, e[63:32]);
            chk("sb_instr", if_instr, e[31:0]);
         end
      end
   end

   initial begin
      rst = 1'b1;
      take_branch = 1'b0;
      branch_target_NextPC = 32'h0;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data = 32'h0;
      if_ready = 1'b1;
      tick();
      tick();
      chk("rst_if_valid", 32'(if_valid), 32'd0);
      chk("rst_if_pc", if_pc, 32'h0);
      chk("rst_if_instr", if_instr, NOP);
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);

      // Straight-line fetch with a one-cycle memory.
      rst = 1'b0;
      #1;
      chk("req0_valid", 32'(imem_req_valid), 32'd1);
      chk("req0_addr", imem_addr, 32'h0);
      tick();
      chk("busy_no_req", 32'(imem_req_valid), 32'd0);
      rsp(32'h0, 1'b1);
      tick();
      rsp_idle();
      #1;
      chk("out0_valid", 32'(if_valid), 32'd1);
      chk("out0_pc", if_pc, 32'h0);
      chk("out0_instr", if_instr, ins(32'h0));
      chk("req4_valid", 32'(imem_req_valid), 32'd1);
      chk("req4_addr", imem_addr, 32'h4);
      tick();
      chk("drained", 32'(if_valid), 32'd0);
      rsp(32'h4, 1'b1);
      tick();
      rsp_idle();

      // Decode stall holds the buffer and blocks new requests.
      if_ready = 1'b0;
      #1;
      chk("stall_if_valid", 32'(if_valid), 32'd1);
      chk("stall_req", 32'(imem_req_valid), 32'd0);
      repeat (3) begin
         tick();
         chk("stall_pc", if_pc, 32'h4);
         chk("stall_instr", if_instr, ins(32'h4));
         chk("stall_req_hold", 32'(imem_req_valid), 32'd0);
      end
      if_ready = 1'b1;
      #1;
      chk("resume_req", 32'(imem_req_valid), 32'd1);
      chk("resume_addr", imem_addr, 32'h8);
      tick();

      // Redirect while the request to 0x8 is outstanding.
      take_branch = 1'b1;
      branch_target_NextPC = 32'h200;
      #1;
      chk("br1_no_req", 32'(imem_req_valid), 32'd0);
      tick();
      take_branch = 1'b0;
      #1;
      chk("br1_wait_stale", 32'(imem_req_valid), 32'd0);
      rsp(32'h8, 1'b0);
      tick();
      rsp_idle();
      #1;
      chk("stale_dropped", 32'(if_valid), 32'd0);
      chk("br1_req", 32'(imem_req_valid), 32'd1);
      chk("br1_addr", imem_addr, 32'h200);
      tick();
      rsp(32'h200, 1'b1);
      tick();
      rsp_idle();
      #1;
      chk("tgt200_valid", 32'(if_valid), 32'd1);
      chk("tgt200_pc", if_pc, 32'h200);
      chk("next_addr", imem_addr, 32'h204);
      tick();
      rsp(32'h204, 1'b0);
      tick();
      rsp_idle();

      // Redirect with nothing outstanding flushes the buffered 0x204.
      take_branch = 1'b1;
      branch_target_NextPC = 32'h100;
      #1;
      chk("br2_no_req", 32'(imem_req_valid), 32'd0);
      chk("br2_buf_pc", if_pc, 32'h204);
      tick();
      take_branch = 1'b0;
      #1;
      chk("br2_flushed", 32'(if_valid), 32'd0);
      chk("br2_req", 32'(imem_req_valid), 32'd1);
      chk("br2_addr", imem_addr, 32'h100);
      tick();

      // Redirect in the same cycle as the response to 0x100.
      take_branch = 1'b1;
      branch_target_NextPC = 32'h300;
      rsp(32'h100, 1'b0);
      #1;
      chk("br3_no_req", 32'(imem_req_valid), 32'd0);
      tick();
      take_branch = 1'b0;
      rsp_idle();
      #1;
      chk("br3_discard", 32'(if_valid), 32'd0);
      chk("br3_req", 32'(imem_req_valid), 32'd1);
      chk("br3_addr", imem_addr, 32'h300);
      tick();
      rsp(32'h300, 1'b1);
      tick();
      rsp_idle();
      imem_req_ready = 1'b0;
      #1;
      chk("br3_no_drop_valid", 32'(if_valid), 32'd1);
      chk("br3_no_drop_pc", if_pc, 32'h300);
      tick();

      // PC wrap-around.
      imem_req_ready = 1'b1;
      take_branch = 1'b1;
      branch_target_NextPC = 32'hFFFF_FFFC;
      tick();
      take_branch = 1'b0;
      #1;
      chk("wrap_req", 32'(imem_req_valid), 32'd1);
      chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
      tick();
      rsp(32'hFFFF_FFFC, 1'b1);
      tick();
      rsp_idle();
      #1;
      chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
      chk("wrap_next_req", 32'(imem_req_valid), 32'd1);
      chk("wrap_next_addr", imem_addr, 32'h0);
      tick();

      // Asynchronous reset with the request to 0x0 outstanding.
      rst = 1'b1;
      #1;
      chk("arst_req", 32'(imem_req_valid), 32'd0);
      chk("arst_if_valid", 32'(if_valid), 32'd0);
      chk("arst_if_instr", if_instr, NOP);
      chk("arst_if_pc", if_pc, 32'h0);
      tick();
      rst = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data = 32'hBAD0_BAD0;
      #1;
      chk("restart_req", 32'(imem_req_valid), 32'd1);
      chk("restart_addr", imem_addr, 32'h0);
      tick();
      rsp_idle();
      #1;
      chk("late_rsp_ignored", 32'(if_valid), 32'd0);
      rsp(32'h0, 1'b1);
      tick();
      rsp_idle();
      #1;
      chk("restart_pc", if_pc, 32'h0);
      chk("restart_instr", if_instr, ins(32'h0));
      imem_req_ready = 1'b0;
      tick();
      tick();
      chk("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter register and instruction-fetch front end of the pipeline.
- Consumes the branch/jump redirect produced by the next-PC generator in EX (take_branch, branch_target_NextPC).
- Issues requests to instruction memory with one request outstanding at most, and drops stale responses after a redirect.
- Presents fetched instructions to decode through a one-entry valid/ready output buffer.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- INSTR_NOP, 32'h0000_0013, value of if_instr while reset or empty.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- take_branch  input  1  redirect request from the next-PC generator; single-cycle pulse.
- branch_target_NextPC  input  32  redirect target; valid while take_branch=1.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts the request.
- imem_addr  output  32  fetch address; equals pc_q.
- imem_rsp_valid  input  1  response valid; arrives at least 1 cycle after accept.
- imem_rsp_data  input  32  fetched instruction word.
- if_valid  output  1  instruction available to decode.
- if_ready  input  1  decode accepts; low means decode stalls.
- if_pc  output  32  PC of the buffered instruction.
- if_instr  output  32  buffered instruction.

Behaviour:
- State:
  - pc_q: next PC to fetch.
  - outstanding: a request has been accepted and its response has not returned.
  - drop: the outstanding response is stale.
  - req_pc: address of the outstanding request.
  - Output buffer: buf_valid, buf_pc, buf_instr.
- Reset (asynchronous, immediate):
  - pc_q=RESET_PC; outstanding=0; drop=0; buf_valid=0.
  - if_valid=0, if_pc=32'h0, if_instr=INSTR_NOP, imem_req_valid=0.
- imem_req_valid (combinational) = !outstanding && (!buf_valid || if_ready) && !take_branch && !rst.
- Accept, when imem_req_valid && imem_req_ready:
  - outstanding<=1; req_pc<=pc_q; pc_q<=pc_q+4.
  - PC addition wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0).
- Response, when imem_rsp_valid && outstanding:
  - outstanding<=0.
  - If drop=1: discard and clear drop.
  - Otherwise: buf_valid<=1, buf_pc<=req_pc, buf_instr<=imem_rsp_data.
- imem_rsp_valid while outstanding=0 is ignored.
- Decode handshake:
  - if_valid=buf_valid; if_pc/if_instr come from the buffer.
  - Contents stay stable while if_valid && !if_ready.
  - if_valid && if_ready with no new response that cycle: buf_valid<=0.
  - Response and consumption in the same cycle: the buffer loads the new entry (buf_valid stays 1).
- Redirect (take_branch=1) has priority over all other updates:
  - pc_q<=branch_target_NextPC, used as given; JALR bit-0 clearing is already done upstream.
  - buf_valid<=0, flushing the wrong-path instruction even if if_ready=1 that cycle; decode must ignore if_valid in a redirect cycle.
  - No request is issued in the redirect cycle.
  - If outstanding and no response this cycle: drop<=1.
  - If a response arrives in the same cycle: it is discarded, drop stays 0.
- Redirect while drop=1 already: pc_q is updated and drop stays 1 (still only one stale response).
- Latency:
  - Redirect at cycle t with nothing outstanding: imem_addr=target with imem_req_valid=1 at t+1.
  - Response at cycle t: if_valid=1 at t+1.
- Throughput: at most one instruction per 2 cycles (one outstanding request).
- Reset deasserted with a response in flight: outstanding=0, so the response is ignored.

Test Plan:
- Reset release, imem_req_ready=1, 1-cycle memory, if_ready=1:
  - imem_addr sequence 0x0, 0x4, 0x8.
  - if_pc 0x0, 0x4 with matching data.
  - if_instr=0x00000013 during reset.
- Decode stall (if_ready=0 for 3 cycles with buf_valid=1):
  - if_pc/if_instr held.
  - imem_req_valid=0.
  - Fetch resumes the cycle after if_ready=1.
- Redirect with nothing outstanding (take_branch=1, target 0x0000_0100):
  - imem_req_valid=0 that cycle.
  - Next cycle imem_addr=0x100.
  - Buffered instruction flushed (if_valid=0).
- Redirect while a request to 0x8 is outstanding (target 0x200):
  - 0x8 response discarded, never presented on if_valid.
  - Next request address is 0x200.
  - if_pc=0x200 after its response.
- Redirect coincident with response arrival: response discarded, drop stays 0, next fetch at target.
- Wrap-around and asynchronous reset:
  - pc_q=0xFFFF_FFFC accepted: next imem_addr=0x0.
  - rst asserted mid-outstanding: outputs reset immediately; late imem_rsp_valid ignored; fetch restarts at RESET_PC.
